// File: rtl/ps2_host_transmitter.sv
// Host-to-device PS/2 transmitter: request-to-send, 8 data bits + odd parity + stop
// shifted on device clock falls, then ACK check. Outputs are open-drain pull-down enables.
module ps2_host_transmitter #(
    parameter int INHIBIT_CYCLES = 15000,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       keyb_clk,
    input  logic       kdata,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       keyb_clk_drv,
    output logic       kdata_drv,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RELEASE,
        SHIFT,
        ACK,
        WAIT_IDLE
    } state_e;

    state_e        state_q;
    logic [1:0]    clkSync_q;
    logic [1:0]    dataSync_q;
    logic          clkPrev_q;
    logic [9:0]    frame_q;
    logic [3:0]    bitCnt_q;
    logic [IW-1:0] inhibitCnt_q;
    logic [IW-1:0] inhibitCnt_d;
    logic [TW-1:0] timeoutCnt_q;
    logic [TW-1:0] timeoutCnt_d;
    logic          txReady_q;
    logic          clkDrv_q;
    logic          dataDrv_q;
    logic          txDone_q;
    logic          txError_q;

    logic clkLine;
    logic dataLine;
    logic fall;
    logic activeState;
    logic abort;

    // Idle-high reset on the synchronisers so leaving reset never looks like a falling edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clkSync_q  <= 2'b11;
            dataSync_q <= 2'b11;
            clkPrev_q  <= 1'b1;
        end else begin
            clkSync_q  <= {clkSync_q[0], keyb_clk};
            dataSync_q <= {dataSync_q[0], kdata};
            clkPrev_q  <= clkSync_q[1];
        end
    end

    always_comb begin
        clkLine      = clkSync_q[1];
        dataLine     = dataSync_q[1];
        fall         = clkPrev_q & ~clkLine;
        inhibitCnt_d = (inhibitCnt_q >= INH_LAST) ? inhibitCnt_q : inhibitCnt_q + IW'(1);
        timeoutCnt_d = (timeoutCnt_q >= TO_MAX) ? timeoutCnt_q : timeoutCnt_q + TW'(1);
        activeState  = state_q inside {RELEASE, SHIFT, ACK, WAIT_IDLE};
        // A bus that has already returned to idle in WAIT_IDLE completes rather than times out.
        abort        = activeState && !fall && (timeoutCnt_q >= TO_LAST) &&
                       !(state_q == WAIT_IDLE && clkLine && dataLine);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            frame_q      <= '0;
            bitCnt_q     <= '0;
            inhibitCnt_q <= '0;
            timeoutCnt_q <= '0;
            txReady_q    <= 1'b1;
            clkDrv_q     <= 1'b0;
            dataDrv_q    <= 1'b0;
            txDone_q     <= 1'b0;
            txError_q    <= 1'b0;
        end else begin
            txDone_q  <= 1'b0;
            txError_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (tx_valid) begin
                        frame_q      <= {1'b1, ~^tx_data, tx_data};
                        bitCnt_q     <= '0;
                        inhibitCnt_q <= '0;
                        timeoutCnt_q <= '0;
                        txReady_q    <= 1'b0;
                        clkDrv_q     <= 1'b1;
                        dataDrv_q    <= (INHIBIT_CYCLES <= 1);
                        state_q      <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (inhibitCnt_q >= INH_LAST) begin
                        clkDrv_q     <= 1'b0;
                        dataDrv_q    <= 1'b1;
                        timeoutCnt_q <= '0;
                        state_q      <= RELEASE;
                    end else begin
                        inhibitCnt_q <= inhibitCnt_d;
                        if (inhibitCnt_d == INH_LAST) begin
                            dataDrv_q <= 1'b1;
                        end
                    end
                end
                RELEASE: begin
                    if (fall) begin
                        dataDrv_q <= ~frame_q[0];
                        frame_q   <= {1'b1, frame_q[9:1]};
                        bitCnt_q  <= 4'd1;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (fall) begin
                        dataDrv_q <= ~frame_q[0];
                        frame_q   <= {1'b1, frame_q[9:1]};
                        bitCnt_q  <= bitCnt_q + 4'd1;
                        if (bitCnt_q == 4'd9) begin
                            state_q <= ACK;
                        end
                    end
                end
                ACK: begin
                    if (fall) begin
                        if (dataLine) begin
                            txError_q <= 1'b1;
                            txReady_q <= 1'b1;
                            state_q   <= IDLE;
                        end else begin
                            state_q <= WAIT_IDLE;
                        end
                    end
                end
                WAIT_IDLE: begin
                    if (clkLine && dataLine) begin
                        txDone_q  <= 1'b1;
                        txReady_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (activeState) begin
                timeoutCnt_q <= fall ? '0 : timeoutCnt_d;
            end
            if (abort) begin
                txError_q <= 1'b1;
                txReady_q <= 1'b1;
                clkDrv_q  <= 1'b0;
                dataDrv_q <= 1'b0;
                state_q   <= IDLE;
            end
        end
    end

    assign tx_ready     = txReady_q;
    assign keyb_clk_drv = clkDrv_q;
    assign kdata_drv    = dataDrv_q;
    assign tx_done      = txDone_q;
    assign tx_error     = txError_q;

endmodule
